// File: rtl/flash_pkg.sv
// Shared command codes, FSM encodings and status-register bit positions
// for the NF_* flash responder.
package flash_pkg;

  localparam logic [7:0] CMD_READ_ARRAY  = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS = 8'h70;
  localparam logic [7:0] CMD_CLEAR_SR    = 8'h50;
  localparam logic [7:0] CMD_PROG        = 8'h40;
  localparam logic [7:0] CMD_PROG_ALT    = 8'h10;
  localparam logic [7:0] CMD_ERASE       = 8'h20;
  localparam logic [7:0] CMD_CONFIRM     = 8'hD0;

  typedef logic [2:0] state_t;
  localparam state_t ST_READ_ARRAY  = 3'd0;
  localparam state_t ST_READ_STATUS = 3'd1;
  localparam state_t ST_PROG_SETUP  = 3'd2;
  localparam state_t ST_ERASE_SETUP = 3'd3;
  localparam state_t ST_PROGRAMMING = 3'd4;
  localparam state_t ST_ERASING     = 3'd5;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_WP_ERR    = 1;

  function automatic logic is_busy(input state_t s);
    return (s == ST_PROGRAMMING) || (s == ST_ERASING);
  endfunction

  function automatic logic shows_status(input state_t s);
    return (s == ST_READ_STATUS) || is_busy(s);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a per-bit reset value so idle-high strobes
// come out of reset inactive.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/flash_responder.sv
// Device-side model of a 256x8 StrataFlash-style part on the NF_* bus:
// command FSM, sticky status register, byte program and full erase with STS.
module flash_responder import flash_pkg::*; #(
  parameter int PROG_CYCLES  = 50,
  parameter int ERASE_CYCLES = 500
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic       NF_CE,
  input  logic       NF_OE,
  input  logic       NF_WE,
  input  logic       NF_RP,
  input  logic       NF_WP,
  input  logic       NF_BYTE,
  input  logic [7:0] NF_A,
  inout  wire  [7:0] NF_D,
  output logic       NF_STS
);

  localparam int CNT_MAX = (PROG_CYCLES > ERASE_CYCLES) ? PROG_CYCLES : ERASE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  logic [4:0] ctl_s;
  logic [7:0] a_s, d_s;
  logic       ce_s, oe_s, we_s, rp_s, wp_s;

  // Control strobes reset to their inactive (high) level.
  sync_2ff #(.W(5), .RST_VAL(5'h1F)) u_sync_ctl (
    .clk(CLK_50MHZ), .rst_n(RST),
    .d({NF_WP, NF_RP, NF_WE, NF_OE, NF_CE}), .q(ctl_s)
  );
  sync_2ff #(.W(8)) u_sync_addr (
    .clk(CLK_50MHZ), .rst_n(RST), .d(NF_A), .q(a_s)
  );
  sync_2ff #(.W(8)) u_sync_data (
    .clk(CLK_50MHZ), .rst_n(RST), .d(NF_D), .q(d_s)
  );

  assign {wp_s, rp_s, we_s, oe_s, ce_s} = ctl_s;

  wire unused_ok = ^{NF_BYTE, oe_s};

  state_t        state, state_nx;
  logic [7:0]    sr_err, sr_err_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    sweep, sweep_nx;
  logic          swept, swept_nx;
  logic [7:0]    pa, pa_nx, pd, pd_nx;
  logic          we_q;
  logic [7:0]    a_q, d_q;
  logic [7:0]    rd_q;
  logic          sts_r;
  logic          wr_ev;
  logic [7:0]    status;

  // Contents are stored complemented so an all-zero power-up register
  // state reads back as erased (0xFF) without any reset of the array.
  logic [7:0]    mem_n [256];
  logic          mem_we;
  logic [7:0]    mem_wa, mem_wd_n;

  assign wr_ev = !ce_s && !we_q && we_s;

  always_comb begin
    status           = sr_err;
    status[SR_READY] = !is_busy(state);
  end

  always_comb begin
    state_nx  = state;
    sr_err_nx = sr_err;
    cnt_nx    = cnt;
    sweep_nx  = sweep;
    swept_nx  = swept;
    pa_nx     = pa;
    pd_nx     = pd;
    mem_we    = 1'b0;
    mem_wa    = pa;
    mem_wd_n  = mem_n[pa] | ~pd;
    if (!rp_s) begin
      state_nx  = ST_READ_ARRAY;
      sr_err_nx = '0;
      cnt_nx    = '0;
      sweep_nx  = '0;
      swept_nx  = 1'b0;
    end else begin
      case (state)
        ST_READ_ARRAY, ST_READ_STATUS: begin
          if (wr_ev) begin
            case (d_q)
              CMD_READ_ARRAY:         state_nx  = ST_READ_ARRAY;
              CMD_READ_STATUS:        state_nx  = ST_READ_STATUS;
              CMD_CLEAR_SR:           sr_err_nx = '0;
              CMD_PROG, CMD_PROG_ALT: state_nx  = ST_PROG_SETUP;
              CMD_ERASE:              state_nx  = ST_ERASE_SETUP;
              default: begin
                sr_err_nx[SR_ERASE_ERR] = 1'b1;
                sr_err_nx[SR_PROG_ERR]  = 1'b1;
                state_nx                = ST_READ_ARRAY;
              end
            endcase
          end
        end
        ST_PROG_SETUP: begin
          if (wr_ev) begin
            if (!wp_s) begin
              sr_err_nx[SR_PROG_ERR] = 1'b1;
              sr_err_nx[SR_WP_ERR]   = 1'b1;
              state_nx               = ST_READ_STATUS;
            end else begin
              pa_nx    = a_q;
              pd_nx    = d_q;
              cnt_nx   = '0;
              state_nx = ST_PROGRAMMING;
            end
          end
        end
        ST_PROGRAMMING: begin
          if (cnt == CW'(PROG_CYCLES)) begin
            mem_we   = 1'b1;
            cnt_nx   = '0;
            state_nx = ST_READ_STATUS;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        ST_ERASE_SETUP: begin
          if (wr_ev) begin
            if (d_q != CMD_CONFIRM) begin
              sr_err_nx[SR_ERASE_ERR] = 1'b1;
              sr_err_nx[SR_PROG_ERR]  = 1'b1;
              state_nx                = ST_READ_STATUS;
            end else if (!wp_s) begin
              sr_err_nx[SR_ERASE_ERR] = 1'b1;
              sr_err_nx[SR_WP_ERR]    = 1'b1;
              state_nx                = ST_READ_STATUS;
            end else begin
              sweep_nx = '0;
              swept_nx = 1'b0;
              cnt_nx   = '0;
              state_nx = ST_ERASING;
            end
          end
        end
        ST_ERASING: begin
          // One byte per clock for the sweep, then the tail wait.
          if (!swept) begin
            mem_we   = 1'b1;
            mem_wa   = sweep;
            mem_wd_n = '0;
            sweep_nx = sweep + 8'd1;
            if (sweep == 8'hFF) swept_nx = 1'b1;
          end else if (cnt == CW'(ERASE_CYCLES)) begin
            cnt_nx   = '0;
            swept_nx = 1'b0;
            state_nx = ST_READ_STATUS;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        default: state_nx = ST_READ_ARRAY;
      endcase
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge RST) begin
    if (!RST) begin
      state  <= ST_READ_ARRAY;
      sr_err <= '0;
      cnt    <= '0;
      sweep  <= '0;
      swept  <= 1'b0;
      pa     <= '0;
      pd     <= '0;
      we_q   <= 1'b1;
      a_q    <= '0;
      d_q    <= '0;
      rd_q   <= '0;
      sts_r  <= 1'b1;
    end else begin
      state  <= state_nx;
      sr_err <= sr_err_nx;
      cnt    <= cnt_nx;
      sweep  <= sweep_nx;
      swept  <= swept_nx;
      pa     <= pa_nx;
      pd     <= pd_nx;
      we_q   <= we_s;
      a_q    <= a_s;
      d_q    <= d_s;
      rd_q   <= shows_status(state) ? status : ~mem_n[a_s];
      // Low from the clock after entering busy; high again on the exit clock.
      sts_r  <= !(is_busy(state) && is_busy(state_nx));
    end
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (mem_we) mem_n[mem_wa] <= mem_wd_n;
  end

  assign NF_D   = (!NF_CE && !NF_OE && NF_WE) ? rd_q : 8'hzz;
  assign NF_STS = sts_r;

endmodule
